// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and load-use hazard unit: tracks in-flight writers in a DEPTH-slot
// shift pipeline and picks, per decode operand, the youngest slot to forward from.
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     hold,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [NUM_SRC*5-1:0]     id_rs,
    input  logic [4:0]               id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_is_load,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Slot k (1..DEPTH): k = 1 is EX, increasing toward writeback.
    logic             r_valid [1:DEPTH];
    logic [4:0]       r_rd    [1:DEPTH];
    logic             r_rw    [1:DEPTH];
    logic             r_ld    [1:DEPTH];
    logic [CNT_W-1:0] r_cnt;

    logic [DEPTH:1]             w_writer;
    logic [NUM_SRC-1:0]         w_blocked;
    logic [NUM_SRC*SEL_W-1:0]   w_sel;
    logic [4:0]                 w_rs;
    logic                       w_stall;
    logic                       w_issue;

    always_comb begin
        w_writer = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_writer[k] = r_valid[k] && r_rw[k] && (r_rd[k] != 5'd0);
        end
    end

    // Scan from the oldest slot down so the youngest match overwrites older ones;
    // only that youngest match decides whether the operand is blocked.
    always_comb begin
        w_sel     = '0;
        w_blocked = '0;
        w_rs      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_rs = id_rs[5*i +: 5];
            for (int k = DEPTH; k >= 1; k--) begin
                if (id_valid && (w_rs != 5'd0) && w_writer[k] && (r_rd[k] == w_rs)) begin
                    w_sel[SEL_W*i +: SEL_W] = SEL_W'(k);
                    w_blocked[i]            = r_ld[k] && (k < LOAD_READY);
                end
            end
        end
    end

    assign w_stall = (|w_blocked) && !flush;
    assign w_issue = id_valid && !w_stall && !flush;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_rd[k]    <= 5'd0;
                r_rw[k]    <= 1'b0;
                r_ld[k]    <= 1'b0;
            end
            r_cnt <= '0;
        end else if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_rw[k]    <= r_rw[k-1];
                r_ld[k]    <= r_ld[k-1];
            end
            r_valid[1] <= w_issue;
            r_rd[1]    <= id_rd;
            r_rw[1]    <= id_regwrite;
            r_ld[1]    <= id_is_load;
            if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign fwd_sel   = w_sel;
    assign stall     = w_stall;
    assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: directed scenarios plus a random run, all
// checked against a history-queue model of the in-flight instructions.
module tb_fwd_hazard_scoreboard;

  logic        CLK;
  logic        RST;
  logic        hold;
  logic        flush;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_is_load;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cnt;
  logic [3:0]  fwd_sel_s;
  logic        stall_s;
  logic [3:0]  stall_cnt_s;

  int checks = 0;
  int errors = 0;

  fwd_hazard_scoreboard dut (
    .CLK(CLK), .RST(RST), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  fwd_hazard_scoreboard #(.CNT_W(4)) dut_sat (
    .CLK(CLK), .RST(RST), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .fwd_sel(fwd_sel_s), .stall(stall_s), .stall_cnt(stall_cnt_s)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model: hist[0] is the instruction issued one edge ago (EX), etc.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
  } ent_t;

  ent_t        hist[$];
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt4;

  function automatic int m_sel(int i);
    bit [4:0] rs;
    rs = id_rs[5*i +: 5];
    if (!id_valid || rs == 0) return 0;
    for (int k = 1; k <= 3; k++) begin
      if (hist[k-1].v && hist[k-1].rw && hist[k-1].rd != 0 && hist[k-1].rd == rs) return k;
    end
    return 0;
  endfunction

  function automatic bit m_stall();
    bit b;
    b = 0;
    for (int i = 0; i < 2; i++) begin
      int s;
      s = m_sel(i);
      if (s != 0 && s < 2 && hist[s-1].ld) b = 1;
    end
    return b && !flush;
  endfunction

  function automatic void m_clear();
    ent_t e;
    e = '{v: 0, rd: 0, rw: 0, ld: 0};
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(e);
  endfunction

  // driver tasks
  task automatic drive(input bit v, input bit [4:0] rs0, input bit [4:0] rs1,
                       input bit [4:0] rd, input bit rw, input bit ld);
    id_valid    = v;
    id_rs       = {rs1, rs0};
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
    #1;
  endtask

  task automatic tick();
    bit   st;
    ent_t e;
    st = m_stall();
    @(posedge CLK);
    if (RST) begin
      m_clear();
      m_cnt  = 0;
      m_cnt4 = 0;
    end else if (!hold) begin
      e = '{v: id_valid && !st && !flush, rd: id_rd, rw: id_regwrite, ld: id_is_load};
      hist.push_front(e);
      void'(hist.pop_back());
      if (st) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    hold = 0;
    flush = 0;
    drive(0, 0, 0, 0, 0, 0);
    RST = 1;
    tick();
    RST = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got sel=%0h stall=%0b cnt=%0d want 0 0 0", fwd_sel, stall, stall_cnt);
    end
  endtask

  task automatic test_forward_distance();
    do_reset();
    drive(1, 0, 0, 5, 1, 0);
    tick();
    for (int d = 1; d <= 4; d++) begin
      drive(1, 5, 0, 0, 0, 0);
      checks++;
      if (fwd_sel[1:0] !== 2'(d % 4) || stall !== 1'b0) begin
        errors++;
        $display("FAIL fwd_distance_%0d: got sel=%0d stall=%0b want sel=%0d stall=0", d, fwd_sel[1:0], stall, d % 4);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 7, 1, 1);
    tick();
    drive(1, 12, 7, 12, 1, 0);
    checks++;
    if (stall !== 1'b1 || fwd_sel[3:2] !== 2'd1) begin
      errors++;
      $display("FAIL load_use_stall: got stall=%0b sel1=%0d want 1 1", stall, fwd_sel[3:2]);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || fwd_sel[3:2] !== 2'd2 || stall_cnt !== 16'd1 || fwd_sel[1:0] !== 2'd0) begin
      errors++;
      $display("FAIL load_use_release: got stall=%0b sel1=%0d cnt=%0d sel0=%0d want 0 2 1 0",
               stall, fwd_sel[3:2], stall_cnt, fwd_sel[1:0]);
    end
    tick();
    drive(1, 12, 0, 0, 0, 0);
    checks++;
    if (fwd_sel[1:0] !== 2'd1) begin
      errors++;
      $display("FAIL load_use_reader_issued: got sel0=%0d want 1", fwd_sel[1:0]);
    end
  endtask

  task automatic test_youngest_wins();
    do_reset();
    drive(1, 0, 0, 9, 1, 0); tick();
    drive(1, 0, 0, 9, 1, 0); tick();
    drive(1, 9, 0, 0, 0, 0);
    checks++;
    if (fwd_sel[1:0] !== 2'd1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL youngest_alu: got sel=%0d stall=%0b want 1 0", fwd_sel[1:0], stall);
    end
    do_reset();
    drive(1, 0, 0, 9, 1, 0); tick();
    drive(1, 0, 0, 9, 1, 1); tick();
    drive(1, 9, 0, 0, 0, 0);
    checks++;
    if (fwd_sel[1:0] !== 2'd1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL youngest_load: got sel=%0d stall=%0b want 1 1", fwd_sel[1:0], stall);
    end
  endtask

  task automatic test_x0_invalid();
    do_reset();
    drive(1, 0, 0, 0, 1, 1); tick();
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL x0_reader: got sel=%0h stall=%0b want 0 0", fwd_sel, stall);
    end
    drive(1, 0, 0, 5, 1, 1); tick();
    drive(0, 5, 5, 0, 0, 0);
    checks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL invalid_decode: got sel=%0h stall=%0b want 0 0", fwd_sel, stall);
    end
  endtask

  task automatic test_hold_flush();
    do_reset();
    drive(1, 0, 0, 7, 1, 1); tick();
    drive(1, 0, 7, 0, 0, 0);
    hold = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (stall !== 1'b1 || stall_cnt !== 16'd0) begin
        errors++;
        $display("FAIL hold_stall_%0d: got stall=%0b cnt=%0d want 1 0", c, stall, stall_cnt);
      end
      tick();
    end
    hold = 0;
    #1;
    checks++;
    if (stall !== 1'b1 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL hold_release: got stall=%0b cnt=%0d want 1 0", stall, stall_cnt);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || stall_cnt !== 16'd1 || fwd_sel[3:2] !== 2'd2) begin
      errors++;
      $display("FAIL hold_after: got stall=%0b cnt=%0d sel1=%0d want 0 1 2", stall, stall_cnt, fwd_sel[3:2]);
    end
    do_reset();
    drive(1, 0, 0, 7, 1, 1); tick();
    drive(1, 0, 7, 12, 1, 0);
    flush = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got stall=%0b want 0", stall);
    end
    tick();
    flush = 0;
    drive(1, 12, 7, 0, 0, 0);
    checks++;
    if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd0 || fwd_sel[3:2] !== 2'd2 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL flush_bubble: got stall=%0b sel0=%0d sel1=%0d cnt=%0d want 0 0 2 0",
               stall, fwd_sel[1:0], fwd_sel[3:2], stall_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive(1, 0, 0, 3, 1, 0); tick();
    drive(1, 0, 0, 3, 1, 0); tick();
    drive(1, 0, 0, 3, 1, 1); tick();
    drive(1, 3, 0, 0, 0, 0); tick();
    checks++;
    if (stall_cnt !== 16'd1 || fwd_sel[1:0] !== 2'd2) begin
      errors++;
      $display("FAIL midflight_pre: got cnt=%0d sel=%0d want 1 2", stall_cnt, fwd_sel[1:0]);
    end
    RST = 1;
    tick();
    RST = 0;
    drive(1, 3, 3, 0, 0, 0);
    checks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midflight_post: got sel=%0h stall=%0b cnt=%0d want 0 0 0", fwd_sel, stall, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 7, 0, 7, 1, 1);
    for (int c = 0; c < 40; c++) tick();
    checks++;
    if (stall_cnt_s !== 4'd15 || stall_cnt !== 16'd20) begin
      errors++;
      $display("FAIL saturation: got cnt4=%0d cnt16=%0d want 15 20", stall_cnt_s, stall_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      RST   = ($urandom_range(0, 63) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 5) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      checks++;
      if (fwd_sel[1:0] !== 2'(m_sel(0)) || fwd_sel[3:2] !== 2'(m_sel(1)) || stall !== m_stall() ||
          stall_cnt !== m_cnt || stall_cnt_s !== m_cnt4 || stall_s !== m_stall()) begin
        errors++;
        $display("FAIL random_%0d: got sel=%0h stall=%0b cnt=%0d cnt4=%0d want sel=%0d,%0d stall=%0b cnt=%0d cnt4=%0d",
                 c, fwd_sel, stall, stall_cnt, stall_cnt_s, m_sel(1), m_sel(0), m_stall(), m_cnt, m_cnt4);
      end
      tick();
    end
    RST = 0;
    hold = 0;
    flush = 0;
  endtask

  initial begin
    RST = 1;
    hold = 0;
    flush = 0;
    id_valid = 0;
    id_rs = '0;
    id_rd = '0;
    id_regwrite = 0;
    id_is_load = 0;
    m_clear();
    m_cnt = 0;
    m_cnt4 = 0;
    test_reset();
    test_forward_distance();
    test_load_use();
    test_youngest_wins();
    test_x0_invalid();
    test_hold_flush();
    test_reset_midflight();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_scoreboard.md
# fwd_hazard_scoreboard

Parametrised forwarding and hazard unit for the pipelined OTTER core. It replaces per-stage `rd`/`regWrite` comparisons with an internal shift pipeline of in-flight writers, DEPTH slots deep. Each cycle it computes, for NUM_SRC decode-stage source operands, which slot to forward from. It also detects load-use hazards, asserts `stall`, and counts stall cycles. It sits beside the decode stage and drives the operand muxes and the fetch/decode stall logic.

## Interface
- NUM_SRC, 2: number of decode source operands checked.
- DEPTH, 3: tracked slots after decode (slot 1 = EX, 2 = MEM, 3 = WB).
- LOAD_READY, 2: lowest slot from which a load result can be forwarded; 1 ≤ LOAD_READY ≤ DEPTH.
- CNT_W, 16: stall counter width.
- SEL_W (derived) = $clog2(DEPTH+1).

- CLK  in  1  clock, rising edge.
- RST  in  1  reset; one clock, synchronous, active-high.
- hold  in  1  global freeze (e.g. memory wait); slots do not shift.
- flush  in  1  kill the decode instruction (branch taken in EX).
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  NUM_SRC*5  source addresses; operand i at [5i+4:5i].
- id_rd  in  5  decode destination register.
- id_regwrite  in  1  decode instruction writes `id_rd`.
- id_is_load  in  1  decode instruction is a load.
- fwd_sel  out  NUM_SRC*SEL_W  per operand i at [SEL_W*i+SEL_W-1:SEL_W*i]; 0 = register file, k = forward from slot k.
- stall  out  1  load-use hazard; hold fetch/decode.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Slot k holds {valid, rd, regwrite, is_load}. A slot is a writer when valid && regwrite && rd != 0.
- Match for operand i: `id_valid`, `id_rs[i]` != 0, and the slot is a writer with rd == `id_rs[i]`.
- `fwd_sel[i]` is the lowest k that matches (youngest writer wins). Otherwise it is 0.
- Operand i is blocked when its youngest match is a load with k < LOAD_READY. Older matches are ignored.
- `stall` = (any operand blocked) && !`flush`.
- While `stall` = 1, each operand's `fwd_sel` still reports its youngest match.
- Slot update on the rising edge, in priority order:
  - RST: all slots invalid and `stall_cnt` = 0.
  - else `hold`: all slots and `stall_cnt` unchanged.
  - else slot[k+1] <= slot[k] for k = 1..DEPTH-1; the slot[DEPTH] entry retires.
  - Slot 1 <= {1, `id_rd`, `id_regwrite`, `id_is_load`} if `id_valid` && !`stall` && !`flush`; otherwise slot 1 becomes a bubble (valid = 0).
- `stall_cnt` increments when `stall` && !`hold` && !RST, and saturates at 2^CNT_W−1.
- Writers with rd = 0 are stored but never match.
- When `id_valid` = 0, every `fwd_sel` is 0 and `stall` is 0.

## Timing
- Reset values: every `fwd_sel` = 0, `stall` = 0, `stall_cnt` = 0. All are valid the cycle after RST is sampled.
- `fwd_sel` and `stall` are combinational from `id_*`, `flush` and the slot registers, in the same cycle. There are no combinational paths from `hold` or RST.
- A decode instruction issued at edge t occupies slot k during cycle t+k−1 (no `hold`).
- Load-use, with LOAD_READY = 2:
  - A dependent directly behind a load sees `stall` = 1 for exactly one cycle.
  - The next cycle it reads `fwd_sel` = 2.
  - In general the stall lasts LOAD_READY−1 cycles.
- `hold` during a stall keeps `stall` asserted and frozen, with `stall_cnt` unchanged. The stall completes once `hold` drops.
- `flush` together with a hazard: `stall` = 0 and slot 1 becomes a bubble; the flush wins.
- RST mid-operation discards all in-flight entries. There is no stale forwarding afterwards.

## Test plan
Defaults for all scenarios: DEPTH = 3, LOAD_READY = 2.
1. Forward distance. Issue ALU op, rd = 5. Over the next three cycles, issue readers with `id_rs[0]` = 5 (no other writers). Required `fwd_sel[0]` = 1, 2, 3; the fourth cycle gives 0. `stall` stays 0.
2. Load-use. Issue a load, rd = 7, then a reader with `id_rs[1]` = 7.
   - First cycle: `stall` = 1, `fwd_sel[1]` = 1, then `stall_cnt` = 1.
   - Next cycle: `stall` = 0, `fwd_sel[1]` = 2, and slot 1 holds a bubble.
3. Youngest wins. Writers to x9 in slot 2 (ALU) and slot 1 (ALU), reader with rs = 9: `fwd_sel` = 1. If slot 1 is instead a load: `stall` = 1.
4. x0 and invalid cases.
   - Writer rd = 0, reader rs = 0: `fwd_sel` = 0, `stall` = 0.
   - `id_valid` = 0 with matching rs: `fwd_sel` = 0, `stall` = 0.
5. Hold and flush.
   - Load-use with `hold` = 1 for 3 cycles: `stall` = 1 throughout and `stall_cnt` = 0. After release: one counted stall cycle, then `fwd_sel` = 2.
   - Same hazard with `flush` = 1: `stall` = 0 and slot 1 is a bubble next cycle.
6. Reset mid-flight. Fill all three slots with writers to x3, assert RST for one cycle. Next cycle, a reader of x3 gets `fwd_sel` = 0 and `stall_cnt` = 0. Saturation: force 2^CNT_W−1 stall cycles (CNT_W = 4 build); the count holds at 15.
